// File: rtl/adder_tree.sv
// Pipelined binary adder tree: sums N operands modulo 2^WIDTH.
// One register bank per tree level; accepts a new operand set every cycle.
module adder_tree #(
    parameter int N     = 8,
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in [0:N-1],
    output logic [WIDTH-1:0] sum,
    output logic             out_valid
);

    localparam int L = $clog2(N);

    if (N < 2 || N > 128 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("adder_tree: N must be a power of two in 2..128");
    end

    // Heap layout: node 1 is the root, node i adds children 2i and 2i+1.
    // Children at or beyond N are the leaf operands in[child-N].
    logic [WIDTH-1:0] node [1:N-1];
    logic [WIDTH-1:0] node_next [1:N-1];

    always_comb begin
        node_next = node;
        for (int i = 1; i < N / 2; i++) begin
            node_next[i] = node[2*i] + node[2*i+1];
        end
        for (int i = N / 2; i < N; i++) begin
            node_next[i] = in[2*i-N] + in[2*i+1-N];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node <= '{default: '0};
        end else begin
            node <= node_next;
        end
    end

    logic [L-1:0] valid_pipe;

    if (L == 1) begin : g_vpipe_one
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_pipe <= '0;
            end else begin
                valid_pipe <= in_valid;
            end
        end
    end else begin : g_vpipe_many
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_pipe <= '0;
            end else begin
                valid_pipe <= {valid_pipe[L-2:0], in_valid};
            end
        end
    end

    assign sum       = node[1];
    assign out_valid = valid_pipe[L-1];

endmodule

// File: tb/tb_adder_tree.sv
// Scoreboard bench for adder_tree: one instance each for N = 8..128,
// all fed from the same operand words and valid strobe.
module tb_adder_tree;

    localparam int NDUT = 5;

    typedef struct {
        logic [127:0] v;
        int           t;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         valid;
    logic [127:0] ops [128];
    logic [127:0] sums [NDUT];
    logic         ovs [NDUT];

    exp_t q [NDUT][$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic int sz(input int k);
        return 8 << k;
    endfunction

    function automatic int lat(input int k);
        return 3 + k;
    endfunction

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        logic [127:0] opk [8<<k];
        for (genvar i = 0; i < (8 << k); i++) begin : g_cp
            assign opk[i] = ops[i];
        end
        adder_tree #(
            .N     (8 << k),
            .WIDTH (128)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (valid),
            .in        (opk),
            .sum       (sums[k]),
            .out_valid (ovs[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_rand();
        for (int i = 0; i < 128; i++) begin
            ops[i] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic push_expected();
        logic [127:0] s;
        for (int k = 0; k < NDUT; k++) begin
            s = '0;
            for (int i = 0; i < sz(k); i++) s = s + ops[i];
            q[k].push_back('{v: s, t: cyc + 1});
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(input logic v);
        valid = v;
        if (v) push_expected();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (ovs[k]) begin
                if (q[k].size() == 0) begin
                    check($sformatf("extra_out_n%0d", sz(k)),
                          128'(ovs[k]), 128'd0);
                end else begin
                    mon_e = q[k].pop_front();
                    check($sformatf("sum_n%0d", sz(k)), sums[k], mon_e.v);
                    check($sformatf("lat_n%0d", sz(k)),
                          128'(cyc - mon_e.t), 128'(lat(k) - 1));
                end
            end
        end
    end

    logic vp [7];

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        set_rand();
        repeat (4) begin
            @(negedge clk);
            set_rand();
        end
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("rst_sum_n%0d", sz(k)), sums[k], 128'd0);
            check($sformatf("rst_valid_n%0d", sz(k)), 128'(ovs[k]), 128'd0);
        end
        rst_n = 1'b1;

        // Simple sum: in[i] = i+1
        for (int i = 0; i < 128; i++) ops[i] = 128'(i + 1);
        drive(1'b1);
        drive(1'b0);
        drive(1'b0);
        check("simple_sum", sums[0], 128'd36);
        check("simple_valid", 128'(ovs[0]), 128'd1);
        drive(1'b0);
        check("simple_valid_drop", 128'(ovs[0]), 128'd0);
        repeat (6) drive(1'b0);

        // Wrap-around
        for (int i = 0; i < 128; i++) ops[i] = '1;
        drive(1'b1);
        for (int i = 0; i < 128; i++) ops[i] = '0;
        ops[0] = {1'b1, 127'b0};
        ops[1] = {1'b1, 127'b0};
        drive(1'b1);
        drive(1'b0);
        check("wrap_all_ones", sums[0], {{124{1'b1}}, 4'h8});
        drive(1'b0);
        check("wrap_to_zero", sums[0], 128'd0);
        check("wrap_valid", 128'(ovs[0]), 128'd1);
        repeat (6) drive(1'b0);

        // Streaming random sets
        repeat (10) begin
            set_rand();
            drive(1'b1);
        end
        repeat (8) drive(1'b0);

        // Bubbles
        vp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            set_rand();
            drive(vp[i]);
            if (i >= 2) begin
                check($sformatf("bubble_%0d", i), 128'(ovs[0]),
                      128'(vp[i-2]));
            end
        end
        repeat (6) drive(1'b0);

        // Asynchronous reset with sets in flight
        repeat (3) begin
            set_rand();
            drive(1'b1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("async_sum_n%0d", sz(k)), sums[k], 128'd0);
            check($sformatf("async_valid_n%0d", sz(k)),
                  128'(ovs[k]), 128'd0);
            q[k].delete();
        end
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_rand();
            drive(1'b0);
            check($sformatf("post_rst_quiet_%0d", i), 128'(ovs[4]), 128'd0);
        end

        // Recovery after reset, then drain
        set_rand();
        drive(1'b1);
        set_rand();
        drive(1'b1);
        repeat (10) drive(1'b0);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("drain_n%0d", sz(k)),
                  128'(q[k].size()), 128'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
